// File: rtl/seq_mult.sv
// Multi-cycle shift-add multiplier (signed/unsigned) with start/busy/done handshake.
// Define SEQ_MULT_EARLY_OUT_EN to leave CALC as soon as the remaining multiplier is zero.
module seq_mult #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   z
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t             state_q;
  logic               sgn_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [2*WIDTH-1:0] z_q;

  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   mplier_d;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] prod;
  logic               last_iter;

  // Operands are reduced to magnitudes; the sign is reapplied once at the end.
  always_comb begin
    a_mag    = (is_signed && a[WIDTH-1]) ? -a : a;
    b_mag    = (is_signed && b[WIDTH-1]) ? -b : b;
    acc_d    = acc_q;
    if (mplier_q[0]) begin
      acc_d = acc_q + ({{WIDTH{1'b0}}, mcand_q} << cnt_q);
    end
    mplier_d  = mplier_q >> 1;
    last_iter = (cnt_q == CNT_W'(WIDTH - 1));
`ifdef SEQ_MULT_EARLY_OUT_EN
    if (mplier_d == '0) begin
      last_iter = 1'b1;
    end
`endif
    prod = sgn_q ? -acc_q : acc_q;
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      sgn_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      z_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            sgn_q    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            mcand_q  <= a_mag;
            mplier_q <= b_mag;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_CALC;
          end
        end
        S_CALC: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_q + 1'b1;
          if (last_iter) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          z_q     <= prod;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign z    = z_q;

endmodule
